// File: rtl/spi_cs_arbiter_if.sv
// Requester-facing signal bundle of the SPI chip-select arbiter.
// The arbiter uses the slave modport; whoever drives the requests uses master.
interface spi_cs_arbiter_if #(
    parameter int NumReq = 4
);
    localparam int IdxW = $clog2(NumReq);

    logic [NumReq-1:0] req_i;
    logic [NumReq-1:0] gnt_o;
    logic [IdxW-1:0]   gnt_idx_o;
    logic [NumReq-1:0] cs_no;
    logic              bus_en_o;
    logic              busy_o;
    logic              timeout_o;

    modport master (
        output req_i,
        input  gnt_o, gnt_idx_o, cs_no, bus_en_o, busy_o, timeout_o
    );

    modport slave (
        input  req_i,
        output gnt_o, gnt_idx_o, cs_no, bus_en_o, busy_o, timeout_o
    );
endinterface

// File: rtl/spi_cs_arbiter.sv
// Round-robin arbiter sharing one SPI host between NumReq requesters.
// Sequences each active-low chip select with setup, hold and gap timing,
// gates the host with bus_en_o and forces release after TimeoutCycles.
module spi_cs_arbiter #(
    parameter int NumReq        = 4,
    parameter int CsSetupCycles = 2,
    parameter int CsHoldCycles  = 2,
    parameter int CsGapCycles   = 1,
    parameter int TimeoutCycles = 1024
) (
    input  logic           clk_sys_i,
    input  logic           rst_sys_i,
    spi_cs_arbiter_if.slave bus
);
    localparam int IdxW   = $clog2(NumReq);
    localparam int MaxA   = (CsSetupCycles > CsHoldCycles) ? CsSetupCycles : CsHoldCycles;
    localparam int MaxB   = (CsGapCycles > TimeoutCycles) ? CsGapCycles : TimeoutCycles;
    localparam int MaxCnt = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int CntW   = $clog2(MaxCnt + 1);
    localparam logic [NumReq-1:0] OneLsb = NumReq'(1);

    typedef enum logic [2:0] {IDLE, SETUP, ACTIVE, HOLD, GAP} state_t;

    state_t            state_reg, state_next;
    logic [CntW-1:0]   cnt_reg, cnt_next;
    logic [IdxW-1:0]   ptr_reg, ptr_next;
    logic [NumReq-1:0] gnt_reg, gnt_next;
    logic [IdxW-1:0]   gnt_idx_reg, gnt_idx_next;
    logic [NumReq-1:0] cs_n_reg, cs_n_next;
    logic              bus_en_reg, bus_en_next;
    logic              busy_reg, busy_next;
    logic              timeout_reg, timeout_next;

    logic              pick_found;
    logic [IdxW-1:0]   pick_idx;
    logic [IdxW-1:0]   cand_idx;
    int                cand;
    logic              req_k;

    assign req_k = bus.req_i[gnt_idx_reg];

    // Round-robin pick: first requesting index scanning from ptr upwards with wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 0; i < NumReq; i++) begin
            cand = int'(ptr_reg) + i;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            cand_idx = IdxW'(cand);
            if (!pick_found && bus.req_i[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // State, counters and registered outputs; reset drops CS without hold timing.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            ptr_reg     <= '0;
            gnt_reg     <= '0;
            gnt_idx_reg <= '0;
            cs_n_reg    <= '1;
            bus_en_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            ptr_reg     <= ptr_next;
            gnt_reg     <= gnt_next;
            gnt_idx_reg <= gnt_idx_next;
            cs_n_reg    <= cs_n_next;
            bus_en_reg  <= bus_en_next;
            busy_reg    <= busy_next;
            timeout_reg <= timeout_next;
        end
    end

    // Next-state and next-output logic; one shared counter serves every timed state.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        ptr_next     = ptr_reg;
        gnt_next     = gnt_reg;
        gnt_idx_next = gnt_idx_reg;
        cs_n_next    = cs_n_reg;
        bus_en_next  = bus_en_reg;
        timeout_next = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    state_next   = SETUP;
                    gnt_next     = OneLsb << pick_idx;
                    gnt_idx_next = pick_idx;
                    cs_n_next    = ~(OneLsb << pick_idx);
                    cnt_next     = CntW'(CsSetupCycles - 1);
                end
            end
            SETUP: begin
                if (!req_k) begin
                    // Requester gave up before the bus was enabled.
                    state_next = HOLD;
                    gnt_next   = '0;
                    cnt_next   = CntW'(CsHoldCycles - 1);
                end else if (cnt_reg == '0) begin
                    state_next  = ACTIVE;
                    bus_en_next = 1'b1;
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ACTIVE: begin
                // A normal release on the expiry edge takes priority over the timeout.
                if (!req_k) begin
                    state_next  = HOLD;
                    bus_en_next = 1'b0;
                    gnt_next    = '0;
                    cnt_next    = CntW'(CsHoldCycles - 1);
                end else if (TimeoutCycles != 0 && cnt_reg == CntW'(TimeoutCycles - 1)) begin
                    state_next   = HOLD;
                    bus_en_next  = 1'b0;
                    gnt_next     = '0;
                    cnt_next     = CntW'(CsHoldCycles - 1);
                    timeout_next = 1'b1;
                end else if (TimeoutCycles != 0) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_reg == '0) begin
                    state_next = GAP;
                    cs_n_next  = '1;
                    cnt_next   = CntW'(CsGapCycles - 1);
                    ptr_next   = (gnt_idx_reg == IdxW'(NumReq - 1)) ? '0 : gnt_idx_reg + 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            GAP: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign bus.gnt_o     = gnt_reg;
    assign bus.gnt_idx_o = gnt_idx_reg;
    assign bus.cs_no     = cs_n_reg;
    assign bus.bus_en_o  = bus_en_reg;
    assign bus.busy_o    = busy_reg;
    assign bus.timeout_o = timeout_reg;
endmodule

// File: tb/tb_spi_cs_arbiter.sv
// Self-checking bench for spi_cs_arbiter: a grant scoreboard plus cycle-exact
// checks of CS/bus_en/timeout timing, including a watchdog-disabled instance.
module tb_spi_cs_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];

    always #5 clk = ~clk;

    spi_cs_arbiter_if #(.NumReq(N)) bus ();
    spi_cs_arbiter_if #(.NumReq(N)) bus_nw ();

    spi_cs_arbiter #(
        .NumReq(N), .CsSetupCycles(2), .CsHoldCycles(2), .CsGapCycles(1), .TimeoutCycles(16)
    ) dut (
        .clk_sys_i(clk), .rst_sys_i(rst), .bus(bus.slave)
    );

    spi_cs_arbiter #(
        .NumReq(N), .CsSetupCycles(2), .CsHoldCycles(2), .CsGapCycles(1), .TimeoutCycles(0)
    ) dut_nw (
        .clk_sys_i(clk), .rst_sys_i(rst), .bus(bus_nw.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer and per-cycle invariants, sampled mid-cycle.
    logic [N-1:0] prev_gnt = '0;
    logic [N-1:0] prev_cs  = '1;
    always @(negedge clk) begin
        int  e;
        logic inv;
        if (!rst) begin
            if (bus.gnt_o != '0 && prev_gnt == '0) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_grant", 32'(bus.gnt_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("grant_idx", 32'(bus.gnt_idx_o), e);
                    check_val("grant_onehot", 32'(bus.gnt_o), 32'd1 << e);
                end
            end
            inv = ($countones(~bus.cs_no) <= 1) && $onehot0(bus.gnt_o) &&
                  (!bus.bus_en_o || ($onehot(bus.gnt_o) && ((bus.gnt_o & ~bus.cs_no) == bus.gnt_o)));
            check_val("invariant", 32'(inv), 32'd1);
            check_val("cs_gap", 32'(prev_cs != '1 && bus.cs_no != '1 && prev_cs != bus.cs_no), 32'd0);
        end
        prev_gnt = bus.gnt_o;
        prev_cs  = bus.cs_no;
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.req_i = '0;
        bus_nw.req_i = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Wait for bus_en, keep it for active_cycles, drop the grantee's request,
    // then optionally re-raise it once the gap is reached.
    task automatic serve(input int active_cycles, input bit reraise, input bit drop_all);
        int n;
        logic [1:0] idx;
        n = 0;
        while (!bus.bus_en_o && n < 50) begin
            tick();
            n++;
        end
        check_val("wait_bus_en", 32'(bus.bus_en_o), 32'd1);
        repeat (active_cycles - 1) tick();
        idx = bus.gnt_idx_o;
        if (drop_all) bus.req_i = '0;
        else bus.req_i[idx] = 1'b0;
        tick();
        n = 0;
        while (bus.cs_no != '1 && n < 50) begin
            tick();
            n++;
        end
        check_val("wait_gap", 32'(bus.cs_no), 32'hf);
        if (reraise) bus.req_i[idx] = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy_o && n < 50) begin
            tick();
            n++;
        end
        check_val("wait_idle", 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.req_i = '0;
        bus_nw.req_i = '0;
        do_reset();

        // Reset values.
        check_val("rst_gnt", 32'(bus.gnt_o), 32'd0);
        check_val("rst_gnt_idx", 32'(bus.gnt_idx_o), 32'd0);
        check_val("rst_cs", 32'(bus.cs_no), 32'hf);
        check_val("rst_bus_en", 32'(bus.bus_en_o), 32'd0);
        check_val("rst_busy", 32'(bus.busy_o), 32'd0);
        check_val("rst_timeout", 32'(bus.timeout_o), 32'd0);

        // 1. Single request, cycle-exact.
        bus.req_i = 4'b0010;
        exp_q.push_back(1);
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 1) begin
                check_val("t1_gnt", 32'(bus.gnt_o), 32'h2);
                check_val("t1_cs", 32'(bus.cs_no), 32'hd);
            end
            if (c == 2) check_val("t1_en_early", 32'(bus.bus_en_o), 32'd0);
            if (c == 3) check_val("t1_en", 32'(bus.bus_en_o), 32'd1);
            if (c == 10) begin
                check_val("t1_en_held", 32'(bus.bus_en_o), 32'd1);
                bus.req_i = '0;
            end
            if (c == 11) begin
                check_val("t1_en_drop", 32'(bus.bus_en_o), 32'd0);
                check_val("t1_gnt_drop", 32'(bus.gnt_o), 32'd0);
            end
            if (c == 12) check_val("t1_cs_hold", 32'(bus.cs_no), 32'hd);
            if (c == 13) begin
                check_val("t1_cs_rel", 32'(bus.cs_no), 32'hf);
                check_val("t1_busy_gap", 32'(bus.busy_o), 32'd1);
            end
            if (c == 14) begin
                check_val("t1_busy", 32'(bus.busy_o), 32'd0);
                check_val("t1_idx_held", 32'(bus.gnt_idx_o), 32'd1);
            end
        end

        // 2. Round robin from ptr=0 with everyone requesting.
        do_reset();
        bus.req_i = 4'b1111;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        for (int r = 0; r < 4; r++) serve(4, 1'b1, 1'b0);
        serve(4, 1'b0, 1'b1);
        wait_idle();

        // 3. Wrap: serve requester 2 so ptr becomes 3, then 3 before 0.
        bus.req_i = 4'b0100;
        exp_q.push_back(2);
        serve(3, 1'b0, 1'b0);
        wait_idle();
        bus.req_i = 4'b1001;
        exp_q.push_back(3); exp_q.push_back(0);
        serve(3, 1'b0, 1'b0);
        serve(3, 1'b0, 1'b0);
        wait_idle();

        // 4. Early abort in the second SETUP cycle (ptr is 1 here).
        bus.req_i = 4'b0010;
        exp_q.push_back(1);
        for (int c = 1; c <= 6; c++) begin
            tick();
            check_val("t4_en", 32'(bus.bus_en_o), 32'd0);
            if (c == 1) check_val("t4_cs_setup", 32'(bus.cs_no), 32'hd);
            if (c == 2) bus.req_i = '0;
            if (c == 3) begin
                check_val("t4_gnt", 32'(bus.gnt_o), 32'd0);
                check_val("t4_cs_hold1", 32'(bus.cs_no), 32'hd);
            end
            if (c == 4) check_val("t4_cs_hold2", 32'(bus.cs_no), 32'hd);
            if (c == 5) begin
                check_val("t4_cs_gap", 32'(bus.cs_no), 32'hf);
                check_val("t4_busy_gap", 32'(bus.busy_o), 32'd1);
            end
            if (c == 6) check_val("t4_busy", 32'(bus.busy_o), 32'd0);
        end

        // 5. Watchdog: requester 2 held; re-granted; release on expiry edge wins.
        bus.req_i = 4'b0100;
        bus_nw.req_i = 4'b0100;
        exp_q.push_back(2); exp_q.push_back(2);
        for (int c = 1; c <= 44; c++) begin
            tick();
            check_val("t5_timeout", 32'(bus.timeout_o), 32'(c == 19));
            check_val("t5_en", 32'(bus.bus_en_o), 32'((c >= 3 && c <= 18) || (c >= 25 && c <= 40)));
            check_val("t5_cs", 32'(bus.cs_no),
                      ((c >= 1 && c <= 20) || (c >= 23 && c <= 42)) ? 32'hb : 32'hf);
            check_val("t5_nw_timeout", 32'(bus_nw.timeout_o), 32'd0);
            check_val("t5_nw_en", 32'(bus_nw.bus_en_o), 32'(c >= 3 && c <= 40));
            check_val("t5_nw_cs", 32'(bus_nw.cs_no), (c <= 42) ? 32'hb : 32'hf);
            if (c == 40) begin
                bus.req_i = '0;
                bus_nw.req_i = '0;
            end
        end
        wait_idle();

        // 6. Reset in ACTIVE (ptr is 3 here), then ptr=0 picks requester 1.
        bus.req_i = 4'b1000;
        exp_q.push_back(3);
        begin
            int n;
            n = 0;
            while (!bus.bus_en_o && n < 50) begin
                tick();
                n++;
            end
            check_val("t6_wait_en", 32'(bus.bus_en_o), 32'd1);
        end
        tick();
        tick();
        rst = 1'b1;
        bus.req_i = '0;
        tick();
        check_val("t6_cs", 32'(bus.cs_no), 32'hf);
        check_val("t6_en", 32'(bus.bus_en_o), 32'd0);
        check_val("t6_gnt", 32'(bus.gnt_o), 32'd0);
        check_val("t6_busy", 32'(bus.busy_o), 32'd0);
        check_val("t6_idx", 32'(bus.gnt_idx_o), 32'd0);
        rst = 1'b0;
        tick();
        bus.req_i = 4'b1010;
        exp_q.push_back(1);
        tick();
        check_val("t6_regrant", 32'(bus.gnt_o), 32'h2);
        serve(3, 1'b0, 1'b1);
        wait_idle();

        tick();
        check_val("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "bench timeout");
    end
endmodule
